// File: rtl/proc_host_pkg.sv
// Shared types and default constants for the processor launch host.
package proc_host_pkg;

    localparam int CW_DEF      = 16;
    localparam int TIMEOUT_DEF = 4096;
    localparam int RST_CYC_DEF = 2;
    localparam int RCW         = 4;   // width of the PRST hold counter (RST_CYC <= 15)

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRST,
        S_REQ,
        S_RUN,
        S_FAULT
    } state_e;

endpackage

// File: rtl/proc_host_sat.sv
// Saturating up-counter with synchronous clear and a compare against a fixed terminal value.
module sat_counter #(
    parameter int           W      = 16,
    parameter logic [W-1:0] TC_VAL = '1
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         clear_i,
    input  logic         en_i,
    output logic [W-1:0] count_o,
    output logic         tc_o
);

    logic [W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (en_i && (count_q != '1)) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;
    assign tc_o    = (count_q == TC_VAL);

endmodule

// File: rtl/proc_host.sv
// Launch sequencer: resets the processor, pulses req, times the run and aborts on timeout.
module proc_host
    import proc_host_pkg::*;
#(
    parameter int CW      = CW_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF,
    parameter int RST_CYC = RST_CYC_DEF
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [1:0]    prog_sel,
    input  logic          done,
    output logic          proc_reset,
    output logic          req,
    output logic          busy,
    output logic          finished,
    output logic          timeout,
    output logic [CW-1:0] cycles,
    output logic [1:0]    prog_id
);

    localparam logic [CW-1:0]  TMO_LAST = CW'(TIMEOUT - 1);
    localparam logic [RCW-1:0] RST_LAST = RCW'(RST_CYC - 1);

    state_e         state_q, state_d;
    logic [RCW-1:0] rst_cnt_q, rst_cnt_d;
    logic [1:0]     prog_id_q, prog_id_d;
    logic           timeout_q, timeout_d;
    logic           finished_q, finished_d;
    logic           start_acc, in_run, tmo_hit, cnt_en;

    assign start_acc = start && ((state_q == S_IDLE) || (state_q == S_FAULT));
    assign in_run    = (state_q == S_RUN);
    // done wins over the timeout compare, and the count freezes at the abort point.
    assign cnt_en    = in_run && !done && !tmo_hit;

    sat_counter #(
        .W      (CW),
        .TC_VAL (TMO_LAST)
    ) u_cyc (
        .clk_i   (clk),
        .rst_i   (reset),
        .clear_i (start_acc),
        .en_i    (cnt_en),
        .count_o (cycles),
        .tc_o    (tmo_hit)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_FAULT: if (start) state_d = S_PRST;
            S_PRST:          if (rst_cnt_q == RST_LAST) state_d = S_REQ;
            S_REQ:           state_d = S_RUN;
            S_RUN: begin
                if (done)         state_d = S_IDLE;
                else if (tmo_hit) state_d = S_FAULT;
            end
            default:         state_d = S_IDLE;
        endcase
    end

    // proc_reset also follows the host reset so the processor is held before the first edge.
    always_comb begin
        proc_reset = reset || (state_q == S_PRST) || (state_q == S_FAULT);
        req        = (state_q == S_REQ);
        busy       = (state_q == S_PRST) || (state_q == S_REQ) || (state_q == S_RUN);
    end

    always_comb begin
        rst_cnt_d  = (state_q == S_PRST) ? rst_cnt_q + 1'b1 : '0;
        prog_id_d  = start_acc ? prog_sel : prog_id_q;
        timeout_d  = timeout_q;
        if (start_acc) begin
            timeout_d = 1'b0;
        end else if (in_run && !done && tmo_hit) begin
            timeout_d = 1'b1;
        end
        finished_d = in_run && done;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rst_cnt_q  <= '0;
            prog_id_q  <= '0;
            timeout_q  <= 1'b0;
            finished_q <= 1'b0;
        end else begin
            rst_cnt_q  <= rst_cnt_d;
            prog_id_q  <= prog_id_d;
            timeout_q  <= timeout_d;
            finished_q <= finished_d;
        end
    end

    assign finished = finished_q;
    assign timeout  = timeout_q;
    assign prog_id  = prog_id_q;

endmodule

// File: doc/proc_host.md
PROC_HOST -- requirements
Module: proc_host

Interface
REQ-001 Parameter CW, default 16: width of the cycle counter.
REQ-002 Parameter TIMEOUT, default 4096: maximum number of RUN cycles before an abort.
REQ-003 Parameter RST_CYC, default 2: number of cycles proc_reset is held per launch; legal range 1..15.
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 start  input  1  launch request from the bench or host; sampled for one cycle.
REQ-007 prog_sel  input  2  program number, captured when start is accepted.
REQ-008 done  input  1  level-sensitive completion flag from the processor.
REQ-009 proc_reset  output  1  reset driven to the processor.
REQ-010 req  output  1  request pulse driven to the processor.
REQ-011 busy  output  1  high in every state except IDLE and FAULT.
REQ-012 finished  output  1  one-cycle pulse on successful completion.
REQ-013 timeout  output  1  sticky abort flag.
REQ-014 cycles  output  CW  measured run length.
REQ-015 prog_id  output  2  program number of the current or most recent run.

Function
REQ-016 The FSM SHALL have exactly five states: IDLE, PRST, REQ, RUN, FAULT.
REQ-017 In IDLE or FAULT, start=1 SHALL capture prog_sel into prog_id, clear timeout and cycles, and move to PRST.
REQ-018 start SHALL be ignored in PRST, REQ and RUN.
REQ-019 PRST SHALL assert proc_reset for exactly RST_CYC consecutive cycles, then move to REQ.
REQ-020 REQ SHALL last one cycle with req=1 and proc_reset=0, then move to RUN.
REQ-021 req SHALL be 1 only in REQ.
REQ-022 proc_reset SHALL be 1 only in PRST and FAULT.
REQ-023 done SHALL be sampled only in RUN; done in any other state SHALL have no effect.
REQ-024 RUN with done=0: cycles increments by 1, saturating at 2^CW-1.
REQ-025 RUN with done=1: cycles holds its value, finished=1 for that cycle, next state IDLE.
REQ-026 cycles therefore equals the number of RUN cycles observed before done; done already high on the first RUN cycle gives cycles=0.
REQ-027 RUN with done=0 and cycles==TIMEOUT-1: next state FAULT, timeout set to 1, finished stays 0.
REQ-028 If done=1 on the same cycle as the timeout condition, done SHALL win: the run completes normally and no fault is raised.
REQ-029 FAULT SHALL hold proc_reset=1, keep timeout=1 and freeze cycles until start is accepted.
REQ-030 cycles and prog_id SHALL remain stable in IDLE so they can be read after a run.
REQ-031 The timeout comparison SHALL be done at CW bits; TIMEOUT SHALL not exceed 2^CW.

Reset
REQ-032 reset=1 SHALL force IDLE, with req=0, finished=0, timeout=0, cycles=0, prog_id=0.
REQ-033 proc_reset SHALL be 1 while reset=1, and 0 in IDLE after reset is released.
REQ-034 reset SHALL take priority over start and done on the same edge.
REQ-035 reset asserted mid-run SHALL abort the run with no finished pulse.

Structure
REQ-036 A shared package proc_host_pkg SHALL hold the state enum typedef and default constants for CW, TIMEOUT and RST_CYC.
REQ-037 The saturating cycle counter SHALL be one sub-module, sat_counter, with clear, enable and terminal-count outputs.
REQ-038 All outputs SHALL be registered or decoded from state only; there SHALL be no combinational path from done to any output.

Verification
REQ-039 reset, then start with prog_sel=2 and done rising on the 10th RUN cycle -> proc_reset=1 for 2 cycles, req=1 for 1 cycle, finished pulse, cycles=9, prog_id=2, busy=0.
REQ-040 done held at 0 with TIMEOUT=16 -> after 16 RUN cycles state is FAULT, timeout=1, proc_reset=1, cycles=15, no finished pulse.
REQ-041 start pulsed during RUN with prog_sel=3 -> ignored; prog_id unchanged and run length unaffected.
REQ-042 done held at 1 throughout IDLE and PRST -> no effect until RUN; finished on the first RUN cycle with cycles=0.
REQ-043 reset asserted on the 5th RUN cycle -> next cycle is IDLE, all outputs at reset values, no finished pulse; a later start runs normally.
REQ-044 From FAULT, start with prog_sel=1 -> timeout cleared, cycles=0, and a new PRST/REQ/RUN sequence begins.
